// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the RV32I hazard unit:
//               forwarding select encoding, result-select code for loads,
//               and the hard-wired zero register ID.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // E-stage operand source: register file, W-stage result or M-stage result
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  // ResultSrcD code that marks a load instruction
  localparam logic [1:0] RESULT_MEM = 2'b01;

  // x0 is hard-wired to zero and never creates a dependency
  localparam int REG_ZERO = 0;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/riscv_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_hazard_unit_if
// Description : Bundle between the pipeline datapath (master) and the hazard
//               unit (slave): D-stage register IDs and control, branch and
//               memory-ready status in; stall, flush, forward selects and
//               performance counters out.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_hazard_unit_if
  import riscv_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] Rs1D;
  logic [REG_W-1:0] Rs2D;
  logic [REG_W-1:0] RdD;
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             MemAccessD;
  logic             PCSrcE;
  logic             MemReady;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  fwd_sel_t         ForwardAE;
  fwd_sel_t         ForwardBE;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemAccessD, PCSrcE, MemReady,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemAccessD, PCSrcE, MemReady,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, StallCnt, FlushCnt
  );
endinterface : riscv_hazard_unit_if
`default_nettype wire

// File: rtl/riscv_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_sat_counter
// Description : Event counter that adds one per qualifying cycle and sticks
//               at its all-ones value instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_sat_counter #(
  parameter int W = 32
) (
  input  wire logic         Clk,
  input  wire logic         reset,
  input  wire logic         inc,
  output logic [W-1:0]      count
);

  localparam logic [W-1:0] c_max = '1;

  logic [W-1:0] r_count;

  // Count qualifying cycles, holding once the maximum is reached
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule : riscv_sat_counter
`default_nettype wire

// File: rtl/riscv_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_hazard_unit
// Description : Hazard, forwarding and stall control for a 5-stage RV32I
//               pipeline. Tracks register IDs through E/M/W, raises
//               load-use / RAW interlocks, data-memory wait stalls and
//               branch flushes, and counts stall and flush cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  wire logic          Clk,
  input  wire logic          reset,
  riscv_hazard_unit_if.slave hz
);

  localparam logic [REG_W-1:0] c_reg_zero = REG_W'(REG_ZERO);

  // Shadow copies of instruction fields as they move through E, M and W
  logic [REG_W-1:0] r_rs1_e, r_rs2_e, r_rd_e;
  logic             r_reg_write_e, r_load_e, r_mem_access_e;
  logic [REG_W-1:0] r_rd_m;
  logic             r_reg_write_m, r_mem_access_m;
  logic [REG_W-1:0] r_rd_w;
  logic             r_reg_write_w;

  logic w_mem_stall, w_e_hits, w_m_hits, w_lw_stall, w_raw_stall;
  logic w_d_stall, w_branch;
  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_w;
  fwd_sel_t w_fwd_a, w_fwd_b;
  logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

  // Hazard detection terms seen by the instruction currently in D
  always_comb begin
    w_mem_stall = r_mem_access_m & ~hz.MemReady;
    w_e_hits    = (r_rd_e != c_reg_zero) && ((r_rd_e == hz.Rs1D) || (r_rd_e == hz.Rs2D));
    w_m_hits    = (r_rd_m != c_reg_zero) && ((r_rd_m == hz.Rs1D) || (r_rd_m == hz.Rs2D));
    w_lw_stall  = r_load_e & w_e_hits;
    // Without forwarding every pending E/M write blocks D; W is written through
    w_raw_stall = w_lw_stall | (r_reg_write_e & w_e_hits) | (r_reg_write_m & w_m_hits);
    w_d_stall   = (FWD_EN != 0) ? w_lw_stall : w_raw_stall;
    w_branch    = hz.PCSrcE & ~w_mem_stall;
  end

  // Stall/flush priority: reset, memory wait, taken branch, D interlock
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (reset) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_w = 1'b1;
    end else if (w_mem_stall) begin
      // Freeze F..M; W receives a bubble so nothing retires twice
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (w_branch) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_d_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  // Operand bypass select: youngest producer (M) wins over W
  always_comb begin
    w_fwd_a = FWD_NONE;
    w_fwd_b = FWD_NONE;
    if (!reset && (FWD_EN != 0)) begin
      if (r_reg_write_m && (r_rd_m != c_reg_zero) && (r_rd_m == r_rs1_e)) begin
        w_fwd_a = FWD_M;
      end else if (r_reg_write_w && (r_rd_w != c_reg_zero) && (r_rd_w == r_rs1_e)) begin
        w_fwd_a = FWD_W;
      end
      if (r_reg_write_m && (r_rd_m != c_reg_zero) && (r_rd_m == r_rs2_e)) begin
        w_fwd_b = FWD_M;
      end else if (r_reg_write_w && (r_rd_w != c_reg_zero) && (r_rd_w == r_rs2_e)) begin
        w_fwd_b = FWD_W;
      end
    end
  end

  // Advance the tracked instruction fields unless the stage is held
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_rs1_e        <= '0;
      r_rs2_e        <= '0;
      r_rd_e         <= '0;
      r_reg_write_e  <= 1'b0;
      r_load_e       <= 1'b0;
      r_mem_access_e <= 1'b0;
      r_rd_m         <= '0;
      r_reg_write_m  <= 1'b0;
      r_mem_access_m <= 1'b0;
      r_rd_w         <= '0;
      r_reg_write_w  <= 1'b0;
    end else begin
      if (!w_stall_e) begin
        if (w_flush_e) begin
          r_rs1_e        <= '0;
          r_rs2_e        <= '0;
          r_rd_e         <= '0;
          r_reg_write_e  <= 1'b0;
          r_load_e       <= 1'b0;
          r_mem_access_e <= 1'b0;
        end else begin
          r_rs1_e        <= hz.Rs1D;
          r_rs2_e        <= hz.Rs2D;
          r_rd_e         <= hz.RdD;
          r_reg_write_e  <= hz.RegWriteD;
          r_load_e       <= (hz.ResultSrcD == RESULT_MEM);
          r_mem_access_e <= hz.MemAccessD;
        end
      end
      if (!w_stall_m) begin
        r_rd_m         <= r_rd_e;
        r_reg_write_m  <= r_reg_write_e;
        r_mem_access_m <= r_mem_access_e;
      end
      if (w_flush_w) begin
        r_rd_w        <= '0;
        r_reg_write_w <= 1'b0;
      end else begin
        r_rd_w        <= r_rd_m;
        r_reg_write_w <= r_reg_write_m;
      end
    end
  end

  riscv_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .reset (reset),
    .inc   (w_stall_f),
    .count (w_stall_cnt)
  );

  riscv_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .reset (reset),
    .inc   (w_branch),
    .count (w_flush_cnt)
  );

  assign hz.StallF    = w_stall_f;
  assign hz.StallD    = w_stall_d;
  assign hz.StallE    = w_stall_e;
  assign hz.StallM    = w_stall_m;
  assign hz.FlushD    = w_flush_d;
  assign hz.FlushE    = w_flush_e;
  assign hz.FlushW    = w_flush_w;
  assign hz.ForwardAE = w_fwd_a;
  assign hz.ForwardBE = w_fwd_b;
  assign hz.StallCnt  = w_stall_cnt;
  assign hz.FlushCnt  = w_flush_cnt;

endmodule : riscv_hazard_unit
`default_nettype wire

// File: tb/tb_riscv_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_hazard_unit
// Description : Random-stimulus scoreboard bench. Two hazard units (with and
//               without forwarding, small counters so saturation is reached)
//               see identical inputs; a pipeline reference model predicts
//               each cycle's outputs and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_hazard_unit;
  import riscv_pkg::*;

  localparam int N_CYCLES = 4000;

  logic Clk;
  logic reset;

  riscv_hazard_unit_if #(.REG_W(5), .CNT_W(3)) if_f ();
  riscv_hazard_unit_if #(.REG_W(5), .CNT_W(5)) if_n ();

  riscv_hazard_unit #(.REG_W(5), .FWD_EN(1), .CNT_W(3)) dut_f (
    .Clk   (Clk),
    .reset (reset),
    .hz    (if_f.slave)
  );

  riscv_hazard_unit #(.REG_W(5), .FWD_EN(0), .CNT_W(5)) dut_n (
    .Clk   (Clk),
    .reset (reset),
    .hz    (if_n.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One instruction as seen by the hazard logic
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       we, load, mem;
  } ins_t;

  typedef struct packed {
    logic [0:0]  k;
    logic [6:0]  ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    logic [3:0]  fwd;   // {ForwardAE,ForwardBE}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference pipeline contents, one per DUT (0: forwarding, 1: interlock)
  ins_t        st_e[2], st_m[2], st_w[2];
  int unsigned cnt_s[2], cnt_f[2];
  int unsigned cnt_max[2];

  function automatic bit reads(logic [4:0] rd, ins_t d);
    return (rd != 5'd0) && ((rd == d.rs1) || (rd == d.rs2));
  endfunction

  function automatic logic [1:0] src_of(ins_t m, ins_t w, logic [4:0] rs);
    if (m.we && m.rd != 5'd0 && m.rd == rs) return 2'b10;
    if (w.we && w.rd != 5'd0 && w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int unsigned bump(int unsigned v, int unsigned vmax);
    return (v >= vmax) ? vmax : v + 1;
  endfunction

  // Predict this cycle's outputs for DUT k and move the model past the edge
  task automatic model_step(input int k, input bit rst, input ins_t d,
                            input bit pc, input bit ready);
    exp_t e;
    bit   mwait, lw, raw, dhaz, br;
    bit   sf, sd, se, sm, fd, fe, fw;
    e       = '0;
    e.k     = 1'(k);
    e.sc    = cnt_s[k];
    e.fc    = cnt_f[k];
    mwait   = st_m[k].mem && !ready;
    lw      = st_e[k].load && reads(st_e[k].rd, d);
    raw     = lw || (st_e[k].we && reads(st_e[k].rd, d)) || (st_m[k].we && reads(st_m[k].rd, d));
    dhaz    = (k == 0) ? lw : raw;
    br      = pc && !mwait;
    {sf, sd, se, sm, fd, fe, fw} = '0;
    if (rst) begin
      {fd, fe, fw} = 3'b111;
    end else if (mwait) begin
      {sf, sd, se, sm, fw} = 5'b11111;
    end else if (br) begin
      {fd, fe} = 2'b11;
    end else if (dhaz) begin
      {sf, sd, fe} = 3'b111;
    end
    e.ctl = {sf, sd, se, sm, fd, fe, fw};
    if (!rst && k == 0)
      e.fwd = {src_of(st_m[k], st_w[k], st_e[k].rs1), src_of(st_m[k], st_w[k], st_e[k].rs2)};
    q.push_back(e);

    if (rst) begin
      st_e[k] = '0; st_m[k] = '0; st_w[k] = '0;
      cnt_s[k] = 0; cnt_f[k] = 0;
    end else begin
      if (sf) cnt_s[k] = bump(cnt_s[k], cnt_max[k]);
      if (br) cnt_f[k] = bump(cnt_f[k], cnt_max[k]);
      st_w[k] = fw ? '0 : st_m[k];
      if (!sm) st_m[k] = st_e[k];
      if (!se) st_e[k] = fe ? '0 : d;
    end
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, req);
    end
  endtask

  // Monitor: compare every queued prediction against the live DUT outputs
  initial begin
    exp_t e;
    logic [6:0]  ctl;
    logic [3:0]  fwd;
    logic [31:0] sc, fc;
    forever begin
      @(negedge Clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.k == 1'b0) begin
          ctl = {if_f.StallF, if_f.StallD, if_f.StallE, if_f.StallM,
                 if_f.FlushD, if_f.FlushE, if_f.FlushW};
          fwd = {2'(if_f.ForwardAE), 2'(if_f.ForwardBE)};
          sc  = 32'(if_f.StallCnt);
          fc  = 32'(if_f.FlushCnt);
        end else begin
          ctl = {if_n.StallF, if_n.StallD, if_n.StallE, if_n.StallM,
                 if_n.FlushD, if_n.FlushE, if_n.FlushW};
          fwd = {2'(if_n.ForwardAE), 2'(if_n.ForwardBE)};
          sc  = 32'(if_n.StallCnt);
          fc  = 32'(if_n.FlushCnt);
        end
        check("stall_flush", int'(e.k), 32'(ctl), 32'(e.ctl));
        check("forward",     int'(e.k), 32'(fwd), 32'(e.fwd));
        check("stall_cnt",   int'(e.k), sc, e.sc);
        check("flush_cnt",   int'(e.k), fc, e.fc);
      end
    end
  end

  task automatic drive(input bit rst, input ins_t d, input logic [1:0] rsrc,
                       input bit pc, input bit ready);
    reset           = rst;
    if_f.Rs1D       = d.rs1;  if_n.Rs1D       = d.rs1;
    if_f.Rs2D       = d.rs2;  if_n.Rs2D       = d.rs2;
    if_f.RdD        = d.rd;   if_n.RdD        = d.rd;
    if_f.RegWriteD  = d.we;   if_n.RegWriteD  = d.we;
    if_f.ResultSrcD = rsrc;   if_n.ResultSrcD = rsrc;
    if_f.MemAccessD = d.mem;  if_n.MemAccessD = d.mem;
    if_f.PCSrcE     = pc;     if_n.PCSrcE     = pc;
    if_f.MemReady   = ready;  if_n.MemReady   = ready;
  endtask

  // Driver: random instructions over a small register set to provoke hazards
  initial begin
    ins_t       d;
    logic [1:0] rsrc;
    bit         rst, pc, ready;
    int         r;
    cnt_max[0] = 7;
    cnt_max[1] = 31;
    for (int k = 0; k < 2; k++) begin
      st_e[k] = '0; st_m[k] = '0; st_w[k] = '0;
      cnt_s[k] = 0; cnt_f[k] = 0;
    end
    drive(1'b1, '0, 2'b00, 1'b0, 1'b1);
    repeat (2) @(posedge Clk);
    for (int c = 0; c < N_CYCLES; c++) begin
      #1;
      rst   = ($urandom_range(99) < 2);
      pc    = ($urandom_range(99) < 10);
      ready = ($urandom_range(99) < 55);
      d.rs1 = 5'($urandom_range(3));
      d.rs2 = 5'($urandom_range(3));
      d.rd  = 5'($urandom_range(3));
      d.load = ($urandom_range(99) < 30);
      if (d.load) begin
        rsrc = RESULT_MEM;
      end else begin
        r    = int'($urandom_range(2));
        rsrc = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
      end
      d.mem = d.load || ($urandom_range(9) < 2);
      d.we  = d.load || ($urandom_range(9) < 7);
      drive(rst, d, rsrc, pc, ready);
      for (int k = 0; k < 2; k++) model_step(k, rst, d, pc, ready);
      @(posedge Clk);
    end
    repeat (2) @(posedge Clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_riscv_hazard_unit
`default_nettype wire
